sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker_pkg.sv | 19 +
 rtl/sysid_checker_if.sv | 24 ++
 rtl/sysid_checker_timer.sv | 27 ++
 rtl/sysid_checker.sv | 190 +++++++++++++++++++
 tb/tb_sysid_checker.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID / timestamp checker.
// State encoding, Avalon word selects and default expected words.
package sysid_checker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        DONE
    } state_t;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    localparam logic [31:0] DEF_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'd1417934875;

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the
// system-ID peripheral (slave).
interface sysid_checker_if;

    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        output waitrequest,
        output readdata
    );

endinterface

// File: rtl/sysid_checker_timer.sv
// Loadable stall counter; tc flags that the next stall cycle
// reaches LIMIT.
module sysid_checker_timer #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [15:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

    assign tc = (count == 16'(LIMIT - 1));

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID and timestamp words and compares them.
// Optional retry on failure via SYSID_CHECKER_RETRY_EN.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TS,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          AUTO_START         = 1,
    parameter int          MAX_RETRIES        = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    sysid_checker_if.master     bus,
    output logic [31:0]         id_value,
    output logic [31:0]         ts_value,
    output logic                done,
    output logic                id_ok,
    output logic                ts_ok,
    output logic                timeout
);

    state_t state;
    state_t state_next;

    logic first;
    logic timer_load;
    logic timer_en;
    logic tc;
    logic cap_id;
    logic cap_ts;
    logic chk;
    logic to_hit;
    logic clr;
    logic match;
    logic retry_ok;

    assign match = (id_value == EXPECTED_ID)
                && (ts_value == EXPECTED_TIMESTAMP);

`ifdef SYSID_CHECKER_RETRY_EN
    logic [7:0] retries;
    logic       retry_take;

    assign retry_ok = (retries < 8'(MAX_RETRIES));
    assign retry_take = (state_next == RD_ID)
        && ((state == CHECK)
            || ((state == RD_ID || state == RD_TS)
                && bus.waitrequest && tc));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retries <= '0;
        end else if (clr) begin
            retries <= '0;
        end else if (retry_take) begin
            retries <= retries + 8'd1;
        end
    end
`else
    assign retry_ok = 1'b0;
`endif

    sysid_checker_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .en      (timer_en),
        .tc      (tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        bus.read    = 1'b0;
        bus.address = ADDR_ID;
        timer_load  = 1'b1;
        timer_en    = 1'b0;
        cap_id      = 1'b0;
        cap_ts      = 1'b0;
        chk         = 1'b0;
        to_hit      = 1'b0;
        clr         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start || (AUTO_START != 0 && first)) begin
                    clr        = 1'b1;
                    state_next = RD_ID;
                end
            end
            RD_ID: begin
                bus.read = 1'b1;
                if (!bus.waitrequest) begin
                    cap_id     = 1'b1;
                    state_next = RD_TS;
                end else if (tc) begin
                    if (retry_ok) begin
                        state_next = RD_ID;
                    end else begin
                        to_hit     = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    timer_load = 1'b0;
                    timer_en   = 1'b1;
                end
            end
            RD_TS: begin
                bus.read    = 1'b1;
                bus.address = ADDR_TS;
                if (!bus.waitrequest) begin
                    cap_ts     = 1'b1;
                    state_next = CHECK;
                end else if (tc) begin
                    if (retry_ok) begin
                        state_next = RD_ID;
                    end else begin
                        to_hit     = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    timer_load = 1'b0;
                    timer_en   = 1'b1;
                end
            end
            CHECK: begin
                if (!match && retry_ok) begin
                    state_next = RD_ID;
                end else begin
                    chk        = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    clr        = 1'b1;
                    state_next = RD_ID;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // first marks the one cycle after reset release for auto-start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first    <= 1'b1;
            id_value <= '0;
            ts_value <= '0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            first <= 1'b0;
            if (clr) begin
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (cap_id) begin
                id_value <= bus.readdata;
            end
            if (cap_ts) begin
                ts_value <= bus.readdata;
            end
            if (chk) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
            end
            if (to_hit) begin
                timeout <= 1'b1;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
            end
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: behavioural Avalon slave plus a
// transaction-level model of latency, retries and result flags.
module tb_sysid_checker;
    import sysid_checker_pkg::*;

    localparam int          TO     = 8;
    localparam int          MAXR   = 3;
    localparam logic [31:0] EXP_ID = DEF_EXPECTED_ID;
    localparam logic [31:0] EXP_TS = DEF_EXPECTED_TS;
`ifdef SYSID_CHECKER_RETRY_EN
    localparam int ATT = MAXR + 1;
`else
    localparam int ATT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;

    always #5 clock = ~clock;

    sysid_checker_if bus ();

    sysid_checker #(
        .EXPECTED_ID        (EXP_ID),
        .EXPECTED_TIMESTAMP (EXP_TS),
        .TIMEOUT_CYCLES     (TO),
        .AUTO_START         (1),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (bus),
        .id_value (id_value),
        .ts_value (ts_value),
        .done     (done),
        .id_ok    (id_ok),
        .ts_ok    (ts_ok),
        .timeout  (timeout)
    );

    int          checks = 0;
    int          passed = 0;
    int          stall_id = 0;
    int          stall_ts = 0;
    logic [31:0] id_seq [4];
    logic [31:0] ts_word;
    int          id_base = 0;
    logic [31:0] model_id;
    logic [31:0] model_ts;

    int   cur = 0;
    int   id_reads = 0;
    int   ts_reads = 0;
    int   read_cycles = 0;
    int   stab_err = 0;
    bit   prev_wr = 1'b0;
    logic prev_addr = 1'b0;

    // Slave: stalls each read by the programmed count, then returns data
    always @(negedge clock) begin : slave
        int k;
        if (bus.read === 1'b1) begin
            read_cycles++;
            if (prev_wr && bus.address !== prev_addr) stab_err++;
            prev_addr = bus.address;
            if (cur < (bus.address ? stall_ts : stall_id)) begin
                bus.waitrequest = 1'b1;
                bus.readdata    = $urandom;
                cur++;
            end else begin
                bus.waitrequest = 1'b0;
                cur = 0;
                if (bus.address) begin
                    ts_reads++;
                    bus.readdata = ts_word;
                end else begin
                    k = id_reads - id_base;
                    if (k > 3) k = 3;
                    bus.readdata = id_seq[k];
                    id_reads++;
                end
            end
        end else begin
            bus.waitrequest = 1'b0;
            bus.readdata    = $urandom;
            cur = 0;
        end
        prev_wr = (bus.read === 1'b1) && bus.waitrequest;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic predict(input bit stuck, output int lat,
                           output bit eid, output bit ets, output bit eto,
                           output logic [31:0] vid, output logic [31:0] vts,
                           output int nreads);
        logic [31:0] w;
        vid = model_id;
        vts = model_ts;
        eid = 1'b0;
        ets = 1'b0;
        nreads = 0;
        if (stuck) begin
            lat = 1 + ATT * TO;
            eto = 1'b1;
        end else begin
            lat = 1;
            eto = 1'b0;
            for (int a = 0; a < ATT; a++) begin
                w = id_seq[(a > 3) ? 3 : a];
                lat += 3 + stall_id + stall_ts;
                nreads++;
                vid = w;
                vts = ts_word;
                eid = (w == EXP_ID);
                ets = (ts_word == EXP_TS);
                if (eid && ets) break;
            end
        end
    endtask

    task automatic run(input bit use_start, input int ignore_at,
                       output int lat, output logic d1);
        lat = 0;
        d1  = 1'b0;
        if (use_start) begin
            start = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
            lat = 1;
            d1 = done;
        end
        while (done !== 1'b1 && lat < 400) begin
            if (lat == ignore_at) start = 1'b1;
            @(posedge clock);
            #1;
            start = 1'b0;
            lat++;
        end
    endtask

    task automatic do_case(input string tag, input bit use_start,
                           input int ignore_at, input bit stuck);
        int          lat;
        int          elat;
        int          nr;
        int          r0;
        int          rc0;
        bit          eid;
        bit          ets;
        bit          eto;
        logic        d1;
        logic [31:0] vid;
        logic [31:0] vts;
        predict(stuck, elat, eid, ets, eto, vid, vts, nr);
        id_base = id_reads;
        r0  = id_reads;
        rc0 = read_cycles;
        run(use_start, ignore_at, lat, d1);
        if (use_start) check({tag, ".done_clr"}, d1, 0);
        check({tag, ".latency"}, lat, elat);
        check({tag, ".done"}, done, 1);
        check({tag, ".id_ok"}, id_ok, eid);
        check({tag, ".ts_ok"}, ts_ok, ets);
        check({tag, ".timeout"}, timeout, eto);
        check({tag, ".id_value"}, id_value, vid);
        check({tag, ".ts_value"}, ts_value, vts);
        check({tag, ".id_reads"}, id_reads - r0, nr);
        check({tag, ".read_idle"}, bus.read, 0);
        if (stuck) check({tag, ".read_cycles"}, read_cycles - rc0, ATT * TO);
        model_id = vid;
        model_ts = vts;
    endtask

    task automatic fill_id(input logic [31:0] w);
        for (int i = 0; i < 4; i++) id_seq[i] = w;
    endtask

    initial begin
        int n;
        logic [31:0] w;
        reset_n  = 1'b0;
        start    = 1'b0;
        ts_word  = EXP_TS;
        model_id = '0;
        model_ts = '0;
        fill_id(EXP_ID);

        repeat (2) @(posedge clock);
        #1;
        check("rst.read", bus.read, 0);
        check("rst.done", done, 0);
        check("rst.id_value", id_value, 0);
        check("rst.timeout", timeout, 0);

        @(negedge clock);
        reset_n = 1'b1;
        do_case("auto", 1'b0, -1, 1'b0);

        ts_word = 32'h12345678;
        do_case("ts_bad", 1'b1, -1, 1'b0);

        ts_word  = EXP_TS;
        stall_id = 3;
        stall_ts = 3;
        do_case("stall3", 1'b1, 2, 1'b0);
        check("stall3.stable", stab_err, 0);

        stall_id = 100000;
        stall_ts = 0;
        do_case("stuck", 1'b1, -1, 1'b1);
        stall_id = 0;

        id_seq[0] = 32'd5;
        id_seq[1] = 32'd7;
        id_seq[2] = EXP_ID;
        id_seq[3] = EXP_ID;
        do_case("retry", 1'b1, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            stall_id = $urandom_range(0, 4);
            stall_ts = $urandom_range(0, 4);
            w = $urandom_range(0, 1) ? EXP_ID : $urandom;
            fill_id(w);
            ts_word = $urandom_range(0, 1) ? EXP_TS : $urandom;
            do_case($sformatf("rnd%0d", i), 1'b1, -1, 1'b0);
        end
        check("rnd.stable", stab_err, 0);

        fill_id(32'hA5A5A5A5);
        ts_word  = EXP_TS;
        stall_id = 0;
        stall_ts = 6;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        n = 0;
        while (!(bus.read === 1'b1 && bus.address === 1'b1) && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("mid.reach_rd_ts", n < 50, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid.read", bus.read, 0);
        check("mid.address", bus.address, 0);
        check("mid.done", done, 0);
        check("mid.id_value", id_value, 0);
        check("mid.ts_value", ts_value, 0);
        check("mid.id_ok", id_ok, 0);
        check("mid.ts_ok", ts_ok, 0);
        check("mid.timeout", timeout, 0);
        fill_id(EXP_ID);
        stall_ts = 0;
        model_id = '0;
        model_ts = '0;
        @(negedge clock);
        reset_n = 1'b1;
        do_case("post_rst", 1'b0, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
